// File: rtl/ex_core_adder_arb.sv
// ---------------------------------------------------------------------------
// ex_core_adder_arb
//   Round-robin arbiter/sequencer sharing one 4-bit combinational adder
//   (ex_core_adder) among NUM_REQ requesters. One requester is accepted at a
//   time; its operands are registered, the sum is captured one cycle later,
//   and the result is held on a response handshake until accepted.
//
// Ports
//   i_clock        clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_req_valid    per-requester operand-pair valid
//   i_req_a/b      per-requester 4-bit operands
//   o_req_ready    one-hot accept strobe (Mealy on IDLE and i_req_valid)
//   o_rsp_valid    one-hot result valid to the granted requester
//   i_rsp_ready    per-requester result accept
//   o_rsp_sum      (a+b) mod 16
//   o_grant_id     index of the current or last granted requester
//   o_busy         high whenever the FSM is not in IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting; round-robin pick among valid requesters, accept one
// ST_CALC | registered operands drive the adder, sum captured at the edge
// ST_RESP | result presented to grant_id until its rsp_ready is seen
// ---------------------------------------------------------------------------

module ex_core_adder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [3:0] o_sum
);
   // Carry out is intentionally dropped: arithmetic wraps modulo 16.
   assign o_sum = i_a + i_b;
endmodule

module ex_core_adder_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    i_clock,
   input  logic                    i_rst,
   input  logic [NUM_REQ-1:0]      i_req_valid,
   input  logic [NUM_REQ-1:0][3:0] i_req_a,
   input  logic [NUM_REQ-1:0][3:0] i_req_b,
   output logic [NUM_REQ-1:0]      o_req_ready,
   output logic [NUM_REQ-1:0]      o_rsp_valid,
   input  logic [NUM_REQ-1:0]      i_rsp_ready,
   output logic [3:0]              o_rsp_sum,
   output logic [ID_W-1:0]         o_grant_id,
   output logic                    o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          r_state;
   logic [ID_W-1:0] r_last_grant;
   logic [ID_W-1:0] r_grant_id;
   logic [3:0]      r_op_a;
   logic [3:0]      r_op_b;
   logic [3:0]      r_rsp_sum;

   logic [ID_W-1:0] w_winner;
   logic            w_found;
   logic [3:0]      w_sum;
   logic            w_rsp_ack;

   // Round-robin search: start one past the last grant and ascend with wrap,
   // so the most recently served requester has the lowest priority.
   always_comb begin
      int v_idx;
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = (int'(r_last_grant) + 1 + k) % NUM_REQ;
         if (!w_found && i_req_valid[v_idx]) begin
            w_found  = 1'b1;
            w_winner = ID_W'(v_idx);
         end
      end
   end

   ex_core_adder u_adder (
      .i_a   (r_op_a),
      .i_b   (r_op_b),
      .o_sum (w_sum)
   );

   assign w_rsp_ack = i_rsp_ready[r_grant_id];

   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_grant_id   <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_rsp_sum    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_op_a     <= i_req_a[w_winner];
                  r_op_b     <= i_req_b[w_winner];
                  r_grant_id <= w_winner;
                  r_state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_rsp_sum <= w_sum;
               r_state   <= ST_RESP;
            end
            ST_RESP: begin
               // Only the granted requester's rsp_ready can close the response.
               if (w_rsp_ack) begin
                  r_last_grant <= r_grant_id;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_req_ready = '0;
      o_rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_req_ready[i] = (r_state == ST_IDLE) && w_found && (w_winner == ID_W'(i));
         o_rsp_valid[i] = (r_state == ST_RESP) && (r_grant_id == ID_W'(i));
      end
   end

   assign o_rsp_sum  = r_rsp_sum;
   assign o_grant_id = r_grant_id;
   assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: doc/ex_core_adder_arb.md
# ex_core_adder_arb

Round-robin arbiter and sequencer that shares one `ex_core_adder` instance, a 4-bit combinational adder, among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers the operands, captures the adder result, and returns it to the granted requester with a response handshake. It sits in `ex_core` between the requesting pipeline stages and the shared adder datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index.
- `Clock`, in, 1: single clock; all state updates on the rising edge.
- `Rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: requester i holds an operand pair.
- `req_a`, in, `NUM_REQ`x4: operand A per requester.
- `req_b`, in, `NUM_REQ`x4: operand B per requester.
- `req_ready`, out, `NUM_REQ`: one-hot accept strobe. Bit i is high only in the cycle requester i's operands are taken.
- `rsp_valid`, out, `NUM_REQ`: one-hot result-valid to the granted requester.
- `rsp_ready`, in, `NUM_REQ`: requester i accepts its result.
- `rsp_sum`, out, 4: result, (a+b) mod 16.
- `grant_id`, out, `ID_W`: index of the current or last granted requester.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CALC, RESP. The state register is the only control state, together with `last_grant`.
- IDLE:
  - Pick the winner by round-robin among set `req_valid` bits.
  - The search starts at `(last_grant+1) mod NUM_REQ` and ascends with wrap.
  - `req_ready[winner]` is driven combinationally high in the same cycle.
  - On that edge: latch `req_a[winner]` and `req_b[winner]` into `op_a_q`/`op_b_q`, set `grant_id`=winner, go to CALC.
  - If no bit of `req_valid` is set, stay in IDLE with `req_ready`=0.
- CALC:
  - `op_a_q`/`op_b_q` drive the shared adder.
  - Its 4-bit sum is latched into `rsp_sum` at the edge; go to RESP.
  - `req_ready`=0.
- RESP:
  - `rsp_valid[grant_id]`=1 and `rsp_sum` is stable.
  - Hold until `rsp_ready[grant_id]`=1. On that edge: `last_grant`<=`grant_id`, go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- Arithmetic: unsigned 4-bit; the carry out is discarded (15+1 -> 0). There is no overflow flag.
- Requesters may change `req_a`/`req_b`/`req_valid` freely while not accepted. A value is only taken on the accept edge.
- A requester whose valid is held stays pending. Round-robin guarantees service within `NUM_REQ` transactions.
- A requester may re-request in the IDLE cycle right after its response. It still loses to any other pending requester.

## Timing
- Reset values: state=IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_sum`=0, `grant_id`=0, `busy`=0, `last_grant`=`NUM_REQ`-1 (requester 0 wins first).
- Reset has priority over every transition. A reset in CALC or RESP drops the transaction: no response, `rsp_valid` low from the next cycle.
- Latency, with the accept cycle as T:
  - CALC in T+1.
  - `rsp_valid` high from T+2.
  - With `rsp_ready` already high, the handshake completes at the end of T+2 and IDLE resumes at T+3.
  - Minimum throughput: one transaction per 3 cycles.
- `req_ready` is a Mealy output of state IDLE and `req_valid`. All other outputs are registered or decoded from state only.
- Simultaneous `req_valid` on all bits: grants rotate 0,1,2,3,0,...
- `rsp_ready` held low: RESP persists indefinitely. No new grant is issued, and `rsp_sum` and `grant_id` stay stable.

## Test plan
- Reset, then requester 0 sends a=1, b=3 -> `req_ready[0]` high in the accept cycle; `rsp_valid[0]` 2 cycles later with `rsp_sum`=4; `busy` low after the response handshake.
- Wrap: requester 2 sends a=15, b=1 -> `rsp_sum`=0. A second transaction a=9, b=8 -> `rsp_sum`=1.
- All four requesters valid continuously, each with a=i, b=5 -> grant order 0,1,2,3,0 and sums 5,6,7,8,5. Each `rsp_valid` is one-hot matching `grant_id`.
- Backpressure: hold `rsp_ready[1]` low for 5 cycles after `rsp_valid[1]` rises (a=7, b=7) -> `rsp_sum`=14 stable; `req_ready` stays 0 for the other, waiting requesters; IDLE resumes one cycle after `rsp_ready[1]` rises.
- Fairness: requester 0 re-requests immediately while requester 3 is pending -> requester 3 is granted before requester 0's second transaction.
- Reset asserted during CALC with a=2, b=2 -> no `rsp_valid` ever; all outputs at their reset values. The next request from requester 0 completes normally with a correct sum.
